// File: rtl/uncache_store_buffer_if.sv
// Uncached-access bundle between the memory pipeline, the store buffer and the AXI bridge.
//   slave  : view taken by uncache_store_buffer. It receives the pipeline's store and load
//            requests, and it drives the uncache_wr_* and uncache_rd_* requests.
//   master : the opposite view, used by whatever drives the buffer (pipeline and AXI side).
// Pipeline store : st_req, st_size, st_wstrb, st_addr, st_data -> st_ready
// Pipeline load  : ld_req, ld_size, ld_addr -> ld_addr_ok, ld_data_ok, ld_rdata
// Status         : empty (no buffered store, no write or load in flight)
// AXI write      : uncache_wr_req/size/wstrb/addr/data -> uncache_wr_rdy, uncache_wr_bvalid
// AXI read       : uncache_rd_req/size/addr -> uncache_rd_rdy, uncache_ret_valid/data
interface uncache_store_buffer_if;
    logic        st_req;
    logic [2:0]  st_size;
    logic [3:0]  st_wstrb;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;

    logic        ld_req;
    logic [2:0]  ld_size;
    logic [31:0] ld_addr;
    logic        ld_addr_ok;
    logic        ld_data_ok;
    logic [31:0] ld_rdata;

    logic        empty;

    logic        uncache_wr_req;
    logic [2:0]  uncache_wr_size;
    logic [3:0]  uncache_wr_wstrb;
    logic [31:0] uncache_wr_addr;
    logic [31:0] uncache_wr_data;
    logic        uncache_wr_rdy;
    logic        uncache_wr_bvalid;

    logic        uncache_rd_req;
    logic [2:0]  uncache_rd_size;
    logic [31:0] uncache_rd_addr;
    logic        uncache_rd_rdy;
    logic        uncache_ret_valid;
    logic [31:0] uncache_ret_data;

    modport slave (
        input  st_req, st_size, st_wstrb, st_addr, st_data,
        output st_ready,
        input  ld_req, ld_size, ld_addr,
        output ld_addr_ok, ld_data_ok, ld_rdata,
        output empty,
        output uncache_wr_req, uncache_wr_size, uncache_wr_wstrb, uncache_wr_addr,
        output uncache_wr_data,
        input  uncache_wr_rdy, uncache_wr_bvalid,
        output uncache_rd_req, uncache_rd_size, uncache_rd_addr,
        input  uncache_rd_rdy, uncache_ret_valid, uncache_ret_data
    );

    modport master (
        output st_req, st_size, st_wstrb, st_addr, st_data,
        input  st_ready,
        output ld_req, ld_size, ld_addr,
        input  ld_addr_ok, ld_data_ok, ld_rdata,
        input  empty,
        input  uncache_wr_req, uncache_wr_size, uncache_wr_wstrb, uncache_wr_addr,
        input  uncache_wr_data,
        output uncache_wr_rdy, uncache_wr_bvalid,
        input  uncache_rd_req, uncache_rd_size, uncache_rd_addr,
        output uncache_rd_rdy, uncache_ret_valid, uncache_ret_data
    );
endinterface

// File: rtl/uncache_store_buffer.sv
// Ordered uncached-access buffer.
// Stores are posted into a circular FIFO. They are drained one at a time with this sequence:
// write request, accept, B response, pop. Loads wait until every older store has been
// acknowledged, which keeps MMIO accesses in program order. Loads never forward from the
// buffer.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset; drops all entries and any in-flight access
//   bus    : uncache_store_buffer_if.slave (pipeline store/load, empty, AXI uncache_wr/rd)
module uncache_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    uncache_store_buffer_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_REQ  = 2'd1;
    localparam logic [1:0] D_RESP = 2'd2;

    localparam logic L_IDLE = 1'b0;
    localparam logic L_WAIT = 1'b1;

    logic [2:0]  mem_size  [DEPTH];
    logic [3:0]  mem_wstrb [DEPTH];
    logic [31:0] mem_addr  [DEPTH];
    logic [31:0] mem_data  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    drain_q, drain_d;
    logic          load_q, load_d;

    logic st_ready;
    logic push;
    logic pop;
    logic wr_req;
    logic rd_req;
    logic addr_ok;
    logic data_ok;

    // Fullness is judged on the registered count only, so a full buffer refuses a push even
    // in its pop cycle. An outstanding load also blocks stores, so no store can overtake it.
    assign st_ready = (count_q != CNT_FULL) && (load_q == L_IDLE);
    assign push     = bus.st_req && st_ready;
    assign pop      = (drain_q == D_RESP) && bus.uncache_wr_bvalid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Drain FSM: at most one write outstanding. The head entry stays fixed until its B
    // response arrives.
    always_comb begin
        drain_d = drain_q;
        case (drain_q)
            D_IDLE: begin
                if (count_q != '0) begin
                    drain_d = D_REQ;
                end
            end
            D_REQ: begin
                if (bus.uncache_wr_rdy) begin
                    drain_d = D_RESP;
                end
            end
            D_RESP: begin
                if (bus.uncache_wr_bvalid) begin
                    drain_d = (count_d != '0) ? D_REQ : D_IDLE;
                end
            end
            default: drain_d = D_IDLE;
        endcase
    end

    // A store that arrives in the same cycle as a load counts as older, so it blocks the load.
    assign rd_req  = (load_q == L_IDLE) && bus.ld_req && (count_q == '0) &&
                     (drain_q == D_IDLE) && !bus.st_req;
    assign addr_ok = rd_req && bus.uncache_rd_rdy;
    assign data_ok = (load_q == L_WAIT) && bus.uncache_ret_valid;

    always_comb begin
        load_d = load_q;
        if (addr_ok) begin
            load_d = L_WAIT;
        end else if (data_ok) begin
            load_d = L_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drain_q  <= D_IDLE;
            load_q   <= L_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drain_q  <= drain_d;
            load_q   <= load_d;
        end
    end

    // Payload storage is not reset; count and the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_size[wr_ptr_q]  <= bus.st_size;
            mem_wstrb[wr_ptr_q] <= bus.st_wstrb;
            mem_addr[wr_ptr_q]  <= bus.st_addr;
            mem_data[wr_ptr_q]  <= bus.st_data;
        end
    end

    assign wr_req = (drain_q == D_REQ);

    assign bus.st_ready         = st_ready;
    assign bus.empty            = (count_q == '0) && (drain_q == D_IDLE) && (load_q == L_IDLE);

    // Head fields are gated so the write bus reads as zero whenever no request is presented.
    assign bus.uncache_wr_req   = wr_req;
    assign bus.uncache_wr_size  = wr_req ? mem_size[rd_ptr_q]  : '0;
    assign bus.uncache_wr_wstrb = wr_req ? mem_wstrb[rd_ptr_q] : '0;
    assign bus.uncache_wr_addr  = wr_req ? mem_addr[rd_ptr_q]  : '0;
    assign bus.uncache_wr_data  = wr_req ? mem_data[rd_ptr_q]  : '0;

    assign bus.uncache_rd_req   = rd_req;
    assign bus.uncache_rd_size  = bus.ld_size;
    assign bus.uncache_rd_addr  = bus.ld_addr;

    assign bus.ld_addr_ok       = addr_ok;
    assign bus.ld_data_ok       = data_ok;
    assign bus.ld_rdata         = data_ok ? bus.uncache_ret_data : '0;
endmodule

// File: tb/tb_uncache_store_buffer.sv
// Directed bench for uncache_store_buffer.
// A scoreboard queue holds the expected write-bus entries, and a second queue holds the
// expected load data.
module tb_uncache_store_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int PH_WAIT = 0;
    localparam int PH_RESP = 1;

    typedef struct packed {
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic resetn;

    uncache_store_buffer_if bus ();

    uncache_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    entry_t sb[$];
    logic [31:0] ld_sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t gen(input int i);
        entry_t e;
        logic [31:0] iv;
        iv = 32'(i);
        e.size = 3'(i % 3);
        if (e.size == 3'd2) e.wstrb = 4'hF;
        else if (e.size == 3'd1) e.wstrb = iv[0] ? 4'hC : 4'h3;
        else e.wstrb = 4'b0001 << iv[1:0];
        e.addr = 32'h1FD0_0000 + iv * 32'h10;
        e.data = $urandom();
        return e;
    endfunction

    task automatic drive_store(input entry_t e);
        bus.st_req   = 1'b1;
        bus.st_size  = e.size;
        bus.st_wstrb = e.wstrb;
        bus.st_addr  = e.addr;
        bus.st_data  = e.data;
    endtask

    task automatic idle_store();
        bus.st_req   = 1'b0;
        bus.st_size  = '0;
        bus.st_wstrb = '0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
    endtask

    task automatic idle_all();
        idle_store();
        bus.ld_req            = 1'b0;
        bus.ld_size           = '0;
        bus.ld_addr           = '0;
        bus.uncache_wr_rdy    = 1'b0;
        bus.uncache_wr_bvalid = 1'b0;
        bus.uncache_rd_rdy    = 1'b0;
        bus.uncache_ret_valid = 1'b0;
        bus.uncache_ret_data  = '0;
    endtask

    // Compare the presented write head against the oldest expected entry.
    task automatic check_head();
        entry_t e;
        if (sb.size() == 0) begin
            chk("wr_req_unexpected", 32'(bus.uncache_wr_req), 32'd0);
        end else begin
            e = sb.pop_front();
            chk("wr_addr", bus.uncache_wr_addr, e.addr);
            chk("wr_data", bus.uncache_wr_data, e.data);
            chk("wr_wstrb", 32'(bus.uncache_wr_wstrb), 32'(e.wstrb));
            chk("wr_size", 32'(bus.uncache_wr_size), 32'(e.size));
        end
    endtask

    // Push n_push generated stores while acting as the AXI write slave. The slave accepts
    // each request at once and returns bvalid b_delay cycles into the response phase.
    task automatic run_stream(input int base, input int n_push, input int b_delay,
                              input bit no_rd);
        int     pushed = 0;
        int     phase = PH_WAIT;
        int     wait_cnt = 0;
        bit     pushing;
        bit     handshake;
        bit     done = 1'b0;
        entry_t cur;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            cur = gen(base + pushed);
            if (pushed < n_push) drive_store(cur);
            else idle_store();
            bus.uncache_wr_bvalid = (phase == PH_RESP) && (wait_cnt == 0);
            bus.uncache_wr_rdy    = 1'b0;
            #1;
            chk("stream_st_ready", 32'(bus.st_ready), 32'(model_cnt != DEPTH));
            if (no_rd) chk("rd_req_blocked", 32'(bus.uncache_rd_req), 32'd0);
            handshake = 1'b0;
            if (phase == PH_WAIT && bus.uncache_wr_req) begin
                check_head();
                bus.uncache_wr_rdy = 1'b1;
                handshake = 1'b1;
            end else if (phase == PH_RESP) begin
                chk("one_outstanding", 32'(bus.uncache_wr_req), 32'd0);
            end
            pushing = (pushed < n_push) && (model_cnt != DEPTH);
            if (pushing) sb.push_back(cur);
            tick();
            if (pushing) begin
                pushed++;
                model_cnt++;
            end
            if (phase == PH_RESP) begin
                if (wait_cnt == 0) begin
                    model_cnt--;
                    phase = PH_WAIT;
                end else begin
                    wait_cnt--;
                end
            end else if (handshake) begin
                phase = PH_RESP;
                wait_cnt = b_delay;
            end
            done = (pushed == n_push) && (model_cnt == 0) && (phase == PH_WAIT);
        end
        idle_store();
        bus.uncache_wr_bvalid = 1'b0;
        bus.uncache_wr_rdy    = 1'b0;
        chk("stream_done", 32'(done), 32'd1);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        entry_t e;
        entry_t e5;
        idle_all();
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        // Reset values
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_wr_req", 32'(bus.uncache_wr_req), 32'd0);
        chk("rst_wr_addr", bus.uncache_wr_addr, 32'd0);
        chk("rst_rd_req", 32'(bus.uncache_rd_req), 32'd0);
        chk("rst_ld_addr_ok", 32'(bus.ld_addr_ok), 32'd0);
        chk("rst_ld_data_ok", 32'(bus.ld_data_ok), 32'd0);
        chk("rst_ld_rdata", bus.ld_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();

        // Single store; accepted one cycle after the request, B three cycles later
        e.size = 3'd2; e.wstrb = 4'hF; e.addr = 32'h1FD0_F000; e.data = 32'hDEAD_BEEF;
        drive_store(e);
        #1;
        chk("t1_st_ready", 32'(bus.st_ready), 32'd1);
        sb.push_back(e);
        tick();
        model_cnt = 1;
        idle_store();
        #1;
        chk("t1_idle_no_req", 32'(bus.uncache_wr_req), 32'd0);
        chk("t1_not_empty", 32'(bus.empty), 32'd0);
        tick();
        #1;
        chk("t1_wr_req", 32'(bus.uncache_wr_req), 32'd1);
        check_head();
        tick();
        bus.uncache_wr_rdy = 1'b1;
        #1;
        chk("t1_wr_req_held", 32'(bus.uncache_wr_req), 32'd1);
        chk("t1_addr_held", bus.uncache_wr_addr, 32'h1FD0_F000);
        tick();
        bus.uncache_wr_rdy = 1'b0;
        #1;
        chk("t1_resp_no_req", 32'(bus.uncache_wr_req), 32'd0);
        tick();
        tick();
        bus.uncache_wr_bvalid = 1'b1;
        #1;
        chk("t1_empty_in_bvalid", 32'(bus.empty), 32'd0);
        tick();
        bus.uncache_wr_bvalid = 1'b0;
        model_cnt = 0;
        #1;
        chk("t1_empty_after", 32'(bus.empty), 32'd1);
        chk("t1_no_req_after", 32'(bus.uncache_wr_req), 32'd0);
        tick();

        // Fill to DEPTH with the write side stalled; the fifth push must wait
        for (int i = 0; i < 4; i++) begin
            e = gen(100 + i);
            drive_store(e);
            #1;
            chk("t2_ready", 32'(bus.st_ready), 32'd1);
            sb.push_back(e);
            tick();
            model_cnt++;
        end
        e5 = gen(104);
        drive_store(e5);
        #1;
        chk("t2_full", 32'(bus.st_ready), 32'd0);
        chk("t2_wr_req", 32'(bus.uncache_wr_req), 32'd1);
        check_head();
        bus.uncache_wr_rdy = 1'b1;
        tick();
        bus.uncache_wr_rdy = 1'b0;
        bus.uncache_wr_bvalid = 1'b1;
        #1;
        chk("t2_full_in_pop_cycle", 32'(bus.st_ready), 32'd0);
        tick();
        bus.uncache_wr_bvalid = 1'b0;
        model_cnt = 3;
        #1;
        chk("t2_push_after_pop", 32'(bus.st_ready), 32'd1);
        sb.push_back(e5);
        tick();
        model_cnt = 4;
        idle_store();
        run_stream(0, 0, 1, 1'b0);
        #1;
        chk("t2_empty", 32'(bus.empty), 32'd1);
        tick();

        // Load behind two buffered stores
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h1FD0_F100;
        bus.ld_size = 3'd2;
        run_stream(200, 2, 3, 1'b1);
        #1;
        chk("t3_rd_req_issue", 32'(bus.uncache_rd_req), 32'd1);
        chk("t3_rd_addr", bus.uncache_rd_addr, 32'h1FD0_F100);
        chk("t3_rd_size", 32'(bus.uncache_rd_size), 32'd2);
        bus.uncache_rd_rdy = 1'b1;
        #1;
        chk("t3_addr_ok", 32'(bus.ld_addr_ok), 32'd1);
        tick();
        bus.uncache_rd_rdy = 1'b0;
        bus.ld_req = 1'b0;
        #1;
        chk("t3_wait_no_rd_req", 32'(bus.uncache_rd_req), 32'd0);
        chk("t3_wait_no_data", 32'(bus.ld_data_ok), 32'd0);
        chk("t3_wait_not_empty", 32'(bus.empty), 32'd0);
        tick();
        bus.uncache_ret_valid = 1'b1;
        bus.uncache_ret_data  = 32'h1234_5678;
        ld_sb.push_back(32'h1234_5678);
        #1;
        chk("t3_data_ok", 32'(bus.ld_data_ok), 32'd1);
        chk("t3_rdata", bus.ld_rdata, ld_sb.pop_front());
        tick();
        bus.uncache_ret_valid = 1'b0;
        bus.uncache_ret_data  = '0;
        #1;
        chk("t3_data_ok_pulse", 32'(bus.ld_data_ok), 32'd0);
        chk("t3_empty", 32'(bus.empty), 32'd1);
        tick();

        // Store held off while a load is outstanding
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h1FD0_F104;
        #1;
        chk("t4_rd_req", 32'(bus.uncache_rd_req), 32'd1);
        bus.uncache_rd_rdy = 1'b1;
        tick();
        bus.uncache_rd_rdy = 1'b0;
        bus.ld_req = 1'b0;
        e = gen(300);
        drive_store(e);
        #1;
        chk("t4_st_blocked", 32'(bus.st_ready), 32'd0);
        tick();
        #1;
        chk("t4_st_blocked2", 32'(bus.st_ready), 32'd0);
        chk("t4_no_wr_req", 32'(bus.uncache_wr_req), 32'd0);
        bus.uncache_ret_valid = 1'b1;
        bus.uncache_ret_data  = 32'hCAFE_0001;
        ld_sb.push_back(32'hCAFE_0001);
        #1;
        chk("t4_st_blocked_ret", 32'(bus.st_ready), 32'd0);
        chk("t4_data_ok", 32'(bus.ld_data_ok), 32'd1);
        chk("t4_rdata", bus.ld_rdata, ld_sb.pop_front());
        tick();
        bus.uncache_ret_valid = 1'b0;
        bus.uncache_ret_data  = '0;
        #1;
        chk("t4_st_after_ret", 32'(bus.st_ready), 32'd1);
        sb.push_back(e);
        tick();
        model_cnt = 1;
        idle_store();
        run_stream(0, 0, 0, 1'b0);
        tick();

        // Push and pop together at count 2, then a stream that wraps the pointers
        e = gen(500);
        drive_store(e);
        #1;
        sb.push_back(e);
        tick();
        e = gen(501);
        drive_store(e);
        #1;
        sb.push_back(e);
        tick();
        idle_store();
        #1;
        chk("t5_wr_req", 32'(bus.uncache_wr_req), 32'd1);
        check_head();
        bus.uncache_wr_rdy = 1'b1;
        tick();
        bus.uncache_wr_rdy = 1'b0;
        e = gen(502);
        drive_store(e);
        bus.uncache_wr_bvalid = 1'b1;
        #1;
        chk("t5_push_pop_ready", 32'(bus.st_ready), 32'd1);
        sb.push_back(e);
        tick();
        bus.uncache_wr_bvalid = 1'b0;
        idle_store();
        model_cnt = 2;
        #1;
        chk("t5_head_advanced", bus.uncache_wr_addr, sb[0].addr);
        chk("t5_not_full", 32'(bus.st_ready), 32'd1);
        run_stream(600, 8, 0, 1'b0);
        #1;
        chk("t5_empty", 32'(bus.empty), 32'd1);
        tick();

        // Asynchronous reset while waiting for B with three entries buffered
        e = gen(700);
        drive_store(e);
        #1;
        tick();
        e = gen(701);
        drive_store(e);
        #1;
        tick();
        e = gen(702);
        drive_store(e);
        bus.uncache_wr_rdy = 1'b1;
        #1;
        chk("t6_wr_req", 32'(bus.uncache_wr_req), 32'd1);
        tick();
        idle_store();
        bus.uncache_wr_rdy = 1'b0;
        #1;
        chk("t6_in_resp", 32'(bus.uncache_wr_req), 32'd0);
        chk("t6_not_empty", 32'(bus.empty), 32'd0);
        chk("t6_full_ready", 32'(bus.st_ready), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        chk("t6_rst_ready", 32'(bus.st_ready), 32'd1);
        chk("t6_rst_wr_req", 32'(bus.uncache_wr_req), 32'd0);
        chk("t6_rst_wr_addr", bus.uncache_wr_addr, 32'd0);
        sb.delete();
        model_cnt = 0;
        tick();
        resetn = 1'b1;
        bus.uncache_wr_bvalid = 1'b1;
        #1;
        chk("t6_stray_b_no_req", 32'(bus.uncache_wr_req), 32'd0);
        tick();
        bus.uncache_wr_bvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_no_stale_req", 32'(bus.uncache_wr_req), 32'd0);
            chk("t6_still_empty", 32'(bus.empty), 32'd1);
            tick();
        end
        run_stream(800, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
